// File: rtl/io_pad_ctrl.sv
// Pad controller between the user core and the pads: Wishbone-programmable per-pin
// output/direction overrides, a synchronised input path and sticky rising-edge interrupts.
module io_pad_ctrl #(
  parameter int          NUM_IO      = 38,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] ADDR_BASE   = 32'h3000_0000
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic [31:0]       wbs_dat_o,
  output logic              wbs_ack_o,
  input  logic [NUM_IO-1:0] core_out,
  input  logic [NUM_IO-1:0] core_oeb,
  output logic [NUM_IO-1:0] core_in,
  input  logic [NUM_IO-1:0] io_in,
  output logic [NUM_IO-1:0] io_out,
  output logic [NUM_IO-1:0] io_oeb,
  output logic              user_irq
);
  localparam logic [4:0] R_OVR_EN   = 5'd0;
  localparam logic [4:0] R_OVR_OUT  = 5'd1;
  localparam logic [4:0] R_OVR_OEB  = 5'd2;
  localparam logic [4:0] R_IN       = 5'd3;
  localparam logic [4:0] R_IRQ_EN   = 5'd4;
  localparam logic [4:0] R_IRQ_STAT = 5'd5;

  logic [NUM_IO-1:0] r_ovr_en, r_ovr_out, r_ovr_oeb, r_irq_en, r_irq_stat, r_prev;
  logic [SYNC_STAGES-1:0][NUM_IO-1:0] r_sync;
  logic              r_ack, r_irq;
  logic [31:0]       r_dat;

  logic              w_acc, w_wr, w_bank;
  logic [4:0]        w_idx;
  logic [NUM_IO-1:0] w_wm, w_wd, w_sync, w_rise, w_clr, w_rv;
  logic [31:0]       w_rdat;
  logic              w_unused;

  // A hit is taken only while ack is low, so back-to-back strobes get one ack per 2 cycles.
  assign w_acc    = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == ADDR_BASE[31:8]) & ~r_ack;
  assign w_wr     = w_acc & wbs_we_i;
  assign w_idx    = wbs_adr_i[7:3];
  assign w_bank   = wbs_adr_i[2];
  assign w_unused = ^wbs_adr_i[1:0];

  // Per-pin write lane: pin i lives in bank i/32, byte (i%32)/8 of the data word.
  for (genvar i = 0; i < NUM_IO; i++) begin : g_lane
    assign w_wm[i] = (w_bank == 1'(i / 32)) & wbs_sel_i[(i % 32) / 8];
    assign w_wd[i] = wbs_dat_i[i % 32];
  end

  assign w_sync = r_sync[SYNC_STAGES-1];
  assign w_rise = w_sync & ~r_prev & r_irq_en;
  assign w_clr  = (w_wr && w_idx == R_IRQ_STAT) ? (w_wd & w_wm) : '0;

  always_comb begin
    w_rv = '0;
    case (w_idx)
      R_OVR_EN:   w_rv = r_ovr_en;
      R_OVR_OUT:  w_rv = r_ovr_out;
      R_OVR_OEB:  w_rv = r_ovr_oeb;
      R_IN:       w_rv = w_sync;
      R_IRQ_EN:   w_rv = r_irq_en;
      R_IRQ_STAT: w_rv = r_irq_stat;
      default:    w_rv = '0;
    endcase
    w_rdat = '0;
    for (int i = 0; i < NUM_IO; i++)
      if (w_bank == 1'(i / 32)) w_rdat[i % 32] = w_rv[i];
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_ack      <= 1'b0;
      r_dat      <= '0;
      r_irq      <= 1'b0;
      r_sync     <= '0;
      r_prev     <= '0;
      r_ovr_en   <= '0;
      r_ovr_out  <= '0;
      r_ovr_oeb  <= '1;
      r_irq_en   <= '0;
      r_irq_stat <= '0;
    end else begin
      r_ack     <= w_acc;
      r_irq     <= |(r_irq_stat & r_irq_en);
      r_sync[0] <= io_in;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
      r_prev    <= w_sync;
      if (w_acc && !wbs_we_i) r_dat <= w_rdat;
      if (w_wr && w_idx == R_OVR_EN)  r_ovr_en  <= (r_ovr_en  & ~w_wm) | (w_wd & w_wm);
      if (w_wr && w_idx == R_OVR_OUT) r_ovr_out <= (r_ovr_out & ~w_wm) | (w_wd & w_wm);
      if (w_wr && w_idx == R_OVR_OEB) r_ovr_oeb <= (r_ovr_oeb & ~w_wm) | (w_wd & w_wm);
      if (w_wr && w_idx == R_IRQ_EN)  r_irq_en  <= (r_irq_en  & ~w_wm) | (w_wd & w_wm);
      // A new edge in the same cycle as a W1C keeps the flag set.
      r_irq_stat <= (r_irq_stat & ~w_clr) | w_rise;
    end
  end

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;
  assign user_irq  = r_irq;
  assign core_in   = w_sync;
  assign io_out    = (r_ovr_en & r_ovr_out) | (~r_ovr_en & core_out);
  assign io_oeb    = (r_ovr_en & r_ovr_oeb) | (~r_ovr_en & core_oeb);
endmodule

// File: tb/tb_io_pad_ctrl.sv
// Bench for io_pad_ctrl: register-map model checked every cycle plus directed literal checks.
module tb_io_pad_ctrl;
  localparam int          N    = 38;
  localparam int          S    = 2;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [63:0] MASK = (64'd1 << N) - 64'd1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cyc, stb, we;
  logic [3:0]    sel;
  logic [31:0]   adr, dat_i;
  logic [31:0]   dat_o;
  logic          ack;
  logic [N-1:0]  core_out, core_oeb, core_in, io_in, io_out, io_oeb;
  logic          irq;

  int checks = 0;
  int failures = 0;
  bit run_cmp = 0;

  io_pad_ctrl #(.NUM_IO(N), .SYNC_STAGES(S), .ADDR_BASE(BASE)) dut (
    .wb_clk_i(clk), .wb_rst_n(rst_n),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_dat_o(dat_o), .wbs_ack_o(ack),
    .core_out(core_out), .core_oeb(core_oeb), .core_in(core_in),
    .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb), .user_irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ext(input logic [N-1:0] v);
    logic [63:0] r;
    r = '0;
    r[N-1:0] = v;
    return r;
  endfunction

  // Model: the six registers as 64-bit pin vectors, plus a history of sampled pad inputs
  // (samp[0] = newest); the synchronised value is the sample S edges old.
  logic [63:0] m_en, m_out, m_oeb, m_ien, m_stat;
  logic        m_ack, m_irq;
  logic [31:0] m_dat;
  logic [63:0] samp[$];

  task automatic model_reset();
    m_en = '0; m_out = '0; m_oeb = MASK; m_ien = '0; m_stat = '0;
    m_ack = 1'b0; m_irq = 1'b0; m_dat = '0;
    samp.delete();
    for (int i = 0; i <= S; i++) samp.push_back('0);
  endtask

  function automatic logic [31:0] rdval(input logic [5:0] off);
    logic [63:0] v;
    case (off[5:1])
      5'd0: v = m_en;
      5'd1: v = m_out;
      5'd2: v = m_oeb;
      5'd3: v = samp[S-1];
      5'd4: v = m_ien;
      5'd5: v = m_stat;
      default: v = '0;
    endcase
    return off[0] ? v[63:32] : v[31:0];
  endfunction

  task automatic model_step();
    logic [63:0] wm, d, rise;
    logic [5:0]  off;
    bit          acc;
    acc  = cyc && stb && (adr[31:8] == BASE[31:8]) && !m_ack;
    off  = adr[7:2];
    rise = samp[S-1] & ~samp[S] & m_ien;
    m_irq = |(m_stat & m_ien);
    if (acc && !we) m_dat = rdval(off);
    if (acc && we) begin
      wm = '0;
      for (int b = 0; b < 4; b++)
        if (sel[b]) wm[int'(off[0])*32 + b*8 +: 8] = 8'hFF;
      wm = wm & MASK;
      d  = {dat_i, dat_i} & wm;
      case (off[5:1])
        5'd0: m_en  = (m_en  & ~wm) | d;
        5'd1: m_out = (m_out & ~wm) | d;
        5'd2: m_oeb = (m_oeb & ~wm) | d;
        5'd4: m_ien = (m_ien & ~wm) | d;
        5'd5: m_stat = m_stat & ~d;
        default: ;
      endcase
    end
    m_stat = m_stat | rise;
    m_ack  = acc;
    samp.push_front(ext(io_in));
    void'(samp.pop_back());
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  initial forever begin
    @(negedge clk);
    if (run_cmp) begin
      chk("cyc_ack",     ext(N'(ack)), ext(N'(m_ack)));
      chk("cyc_dat",     {32'd0, dat_o}, {32'd0, m_dat});
      chk("cyc_irq",     ext(N'(irq)), ext(N'(m_irq)));
      chk("cyc_core_in", ext(core_in), samp[S-1]);
      chk("cyc_io_out",  ext(io_out), ((m_en & m_out) | (~m_en & ext(core_out))) & MASK);
      chk("cyc_io_oeb",  ext(io_oeb), ((m_en & m_oeb) | (~m_en & ext(core_oeb))) & MASK);
    end
  end

  task automatic wb_xfer(input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] rd, output bit acked);
    int n;
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = w; adr = a; dat_i = d; sel = s;
    acked = 0; rd = '0; n = 0;
    while (!acked && n < 4) begin
      @(posedge clk); #1;
      n++;
      if (ack) begin acked = 1; rd = dat_o; end
    end
    if (acked) begin
      chk("ack_latency", 64'(n), 64'd1);
      @(posedge clk); #1;
      chk("ack_one_cycle", ext(N'(ack)), '0);
    end
    cyc = 0; stb = 0; we = 0;
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] rd;
    bit a;
    wb_xfer(1, BASE + 32'(off), d, s, rd, a);
    chk("wr_acked", 64'(a), 64'd1);
  endtask

  task automatic rd_chk(input string name, input logic [7:0] off, input logic [31:0] exp);
    logic [31:0] rd;
    bit a;
    wb_xfer(0, BASE + 32'(off), 32'h0, 4'hF, rd, a);
    chk("rd_acked", 64'(a), 64'd1);
    chk(name, {32'd0, rd}, {32'd0, exp});
  endtask

  initial begin
    logic [31:0] rd;
    bit a;
    rst_n = 0; cyc = 0; stb = 0; we = 0; sel = 4'h0; adr = '0; dat_i = '0;
    core_out = '1; core_oeb = '0; io_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_io_out",  ext(io_out), ext({N{1'b1}}));
    chk("rst_io_oeb",  ext(io_oeb), '0);
    chk("rst_ack",     ext(N'(ack)), '0);
    chk("rst_dat",     {32'd0, dat_o}, '0);
    chk("rst_irq",     ext(N'(irq)), '0);
    chk("rst_core_in", ext(core_in), '0);
    run_cmp = 1;
    @(negedge clk); #1 rst_n = 1;

    rd_chk("rd_oeb_lo", 8'h10, 32'hFFFF_FFFF);
    rd_chk("rd_oeb_hi", 8'h14, 32'h0000_003F);

    // Override pins 0..2; pin 3 keeps following the core.
    @(posedge clk); #1; core_out = '0; core_oeb = '1;
    wr(8'h08, 32'h5, 4'hF);
    wr(8'h10, 32'h0, 4'hF);
    wr(8'h00, 32'h7, 4'hF);
    chk("ovr_io_out", ext(N'(io_out[3:0])), 64'h5);
    chk("ovr_io_oeb", ext(N'(io_oeb[3:0])), 64'h8);

    wr(8'h0C, 32'hFFFF_FFFF, 4'hF);
    rd_chk("rd_out_hi_trunc", 8'h0C, 32'h0000_003F);
    wr(8'h00, 32'hFFFF_FFFF, 4'b0010);
    rd_chk("rd_en_lo_sel", 8'h00, 32'h0000_FF07);

    // Rising edge on pin 37 (hi bit 5).
    wr(8'h24, 32'h20, 4'hF);
    @(posedge clk); #1; io_in[37] = 1'b1;
    @(posedge clk); #1; chk("edge_sync_k",   ext(N'(core_in[37])), '0);
    @(posedge clk); #1; chk("edge_sync_k1",  ext(N'(core_in[37])), 64'd1);
    @(posedge clk); #1; chk("edge_irq_k2",   ext(N'(irq)), '0);
    @(posedge clk); #1; chk("edge_irq_k3",   ext(N'(irq)), 64'd1);
    rd_chk("rd_stat_hi", 8'h2C, 32'h20);
    rd_chk("rd_in_hi",   8'h1C, 32'h20);
    wr(8'h24, 32'h0, 4'hF);
    chk("masked_irq", ext(N'(irq)), '0);
    rd_chk("rd_stat_kept", 8'h2C, 32'h20);
    wr(8'h24, 32'h20, 4'hF);
    @(posedge clk); #1;
    chk("irq_before_w1c", ext(N'(irq)), 64'd1);
    wr(8'h2C, 32'h20, 4'hF);
    chk("irq_after_w1c", ext(N'(irq)), '0);

    // W1C of pin 0 lands on the same edge that its new rising edge is flagged.
    wr(8'h20, 32'h1, 4'hF);
    @(posedge clk); #1; io_in[0] = 1'b1;
    @(posedge clk);
    wr(8'h28, 32'h1, 4'hF);
    rd_chk("set_wins", 8'h28, 32'h1);
    wr(8'h28, 32'h1, 4'hF);
    @(posedge clk); #1; io_in[0] = 1'b0;
    repeat (6) @(posedge clk);
    rd_chk("fall_no_flag", 8'h28, 32'h0);

    rd_chk("rd_oeb_hi2", 8'h14, 32'h3F);
    rd_chk("rd_unmapped", 8'h40, 32'h0);
    wr(8'h40, 32'hDEAD_BEEF, 4'hF);
    wb_xfer(0, BASE + 32'h100, 32'h0, 4'hF, rd, a);
    chk("out_of_window_noack", 64'(a), '0);

    // Reset while a read is being acknowledged.
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = 0; adr = BASE + 32'h14; sel = 4'hF;
    @(posedge clk); #1;
    chk("midrd_ack", ext(N'(ack)), 64'd1);
    chk("midrd_dat", {32'd0, dat_o}, 64'h3F);
    #2 rst_n = 0;
    #1;
    chk("rst_async_ack", ext(N'(ack)), '0);
    chk("rst_async_dat", {32'd0, dat_o}, '0);
    cyc = 0; stb = 0;
    @(posedge clk); #1 rst_n = 1;
    chk("post_rst_io_out", ext(io_out), ext(core_out));
    rd_chk("post_rst_oeb_lo", 8'h10, 32'hFFFF_FFFF);
    rd_chk("post_rst_en_lo",  8'h00, 32'h0);

    repeat (3) @(posedge clk);
    run_cmp = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule
